// File: rtl/mux8x1_src_seq.sv
// rtl/mux8x1_src_seq.sv - 8x4 register bank feeding an 8:1 mux plus a select scan sequencer
module mux8x1_src_seq #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [3:0] wdata,
  input  logic       start,
  input  logic       loop_en,
  input  logic       stop,
  output logic [3:0] i0,
  output logic [3:0] i1,
  output logic [3:0] i2,
  output logic [3:0] i3,
  output logic [3:0] i4,
  output logic [3:0] i5,
  output logic [3:0] i6,
  output logic [3:0] i7,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       last,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state;
  logic [2:0] sel;
  logic [3:0] dcnt;
  logic [3:0] bank [8];
  logic       step;

  assign step = (dcnt == 4'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) bank[k] <= '0;
    end else if (we) begin
      bank[waddr] <= wdata;
    end
  end

  // dcnt restarts on SCAN entry and every sel change so each entry dwells exactly DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 3'd0;
      dcnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          sel  <= 3'd0;
          dcnt <= 4'd0;
          if (start) state <= SCAN;
        end
        SCAN: begin
          if (stop) begin
            state <= IDLE;
            sel   <= 3'd0;
            dcnt  <= 4'd0;
          end else if (step) begin
            dcnt <= 4'd0;
            if (sel != 3'd7) begin
              sel <= sel + 3'd1;
            end else if (loop_en) begin
              sel <= 3'd0;
            end else begin
              state <= DONE;
            end
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          sel   <= 3'd0;
          dcnt  <= 4'd0;
        end
        default: begin
          state <= IDLE;
          sel   <= 3'd0;
          dcnt  <= 4'd0;
        end
      endcase
    end
  end

  assign i0 = bank[0];
  assign i1 = bank[1];
  assign i2 = bank[2];
  assign i3 = bank[3];
  assign i4 = bank[4];
  assign i5 = bank[5];
  assign i6 = bank[6];
  assign i7 = bank[7];

  assign {s2, s1, s0} = sel;
  assign busy = (state == SCAN);
  assign last = (state == SCAN) && (sel == 3'd7);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mux8x1_src_seq.sv
// tb/tb_mux8x1_src_seq.sv - directed bench for mux8x1_src_seq with DIV=1 and DIV=3 instances
module tb_mux8x1_src_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [3:0] wdata = '0;
  logic       loop_en = 1'b0;
  logic       start1 = 1'b0, stop1 = 1'b0, start3 = 1'b0, stop3 = 1'b0;

  logic [3:0] d1_i [8];
  logic [3:0] d3_i [8];
  logic d1_s0, d1_s1, d1_s2, d1_busy, d1_last, d1_done;
  logic d3_s0, d3_s1, d3_s2, d3_busy, d3_last, d3_done;
  logic [2:0] d1_sel, d3_sel;
  logic [3:0] d1_f;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign d1_sel = {d1_s2, d1_s1, d1_s0};
  assign d3_sel = {d3_s2, d3_s1, d3_s0};
  assign d1_f   = d1_i[d1_sel];

  mux8x1_src_seq #(.DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .start(start1), .loop_en(loop_en), .stop(stop1),
    .i0(d1_i[0]), .i1(d1_i[1]), .i2(d1_i[2]), .i3(d1_i[3]),
    .i4(d1_i[4]), .i5(d1_i[5]), .i6(d1_i[6]), .i7(d1_i[7]),
    .s0(d1_s0), .s1(d1_s1), .s2(d1_s2),
    .busy(d1_busy), .last(d1_last), .done(d1_done)
  );

  mux8x1_src_seq #(.DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .start(start3), .loop_en(loop_en), .stop(stop3),
    .i0(d3_i[0]), .i1(d3_i[1]), .i2(d3_i[2]), .i3(d3_i[3]),
    .i4(d3_i[4]), .i5(d3_i[5]), .i6(d3_i[6]), .i7(d3_i[7]),
    .s0(d3_s0), .s1(d3_s1), .s2(d3_s2),
    .busy(d3_busy), .last(d3_last), .done(d3_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d1(input string tag, input logic [2:0] sel, input logic bsy,
                        input logic lst, input logic dn);
    chk({tag, "_sel"},  8'(d1_sel),  8'(sel));
    chk({tag, "_busy"}, 8'(d1_busy), 8'(bsy));
    chk({tag, "_last"}, 8'(d1_last), 8'(lst));
    chk({tag, "_done"}, 8'(d1_done), 8'(dn));
  endtask

  initial begin
    // 1. reset state and bank fill
    tick(); tick();
    for (int k = 0; k < 8; k++) chk("rst_i", 8'(d1_i[k]), 8'h0);
    chk_d1("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      we = 1'b1; waddr = 3'(k); wdata = 4'(k + 8);
      chk("wr_before", 8'(d1_i[k]), 8'h0);
      tick();
      chk("wr_after1", 8'(d1_i[k]), 8'(k + 8));
      chk("wr_after3", 8'(d3_i[k]), 8'(k + 8));
    end
    we = 1'b0;
    chk_d1("t1_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // 2. DIV=1 single pass
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_d1("t2_scan", 3'(k), 1'b1, (k == 7), 1'b0);
      chk("t2_f", 8'(d1_f), 8'(k + 8));
      tick();
    end
    chk_d1("t2_done", 3'd7, 1'b0, 1'b0, 1'b1);
    tick();
    chk_d1("t2_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // 3. DIV=3 looping scan, stop at sel=5 on the second pass
    loop_en = 1'b1;
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      chk("t3_sel",  8'(d3_sel),  8'((c / 3) % 8));
      chk("t3_busy", 8'(d3_busy), 8'h1);
      chk("t3_done", 8'(d3_done), 8'h0);
      chk("t3_last", 8'(d3_last), 8'(((c / 3) % 8) == 7));
      if (c < 39) tick();
    end
    stop3 = 1'b1; tick(); stop3 = 1'b0;
    chk("t3_stop_busy", 8'(d3_busy), 8'h0);
    chk("t3_stop_sel",  8'(d3_sel),  8'h0);
    chk("t3_stop_done", 8'(d3_done), 8'h0);

    // 4. write entry 4 mid-scan, start pulses ignored
    loop_en = 1'b0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick(); tick();
    chk_d1("t4_sel3", 3'd3, 1'b1, 1'b0, 1'b0);
    we = 1'b1; waddr = 3'd4; wdata = 4'hA; start1 = 1'b1;
    tick();
    we = 1'b0; start1 = 1'b0;
    chk_d1("t4_sel4", 3'd4, 1'b1, 1'b0, 1'b0);
    chk("t4_i4", 8'(d1_i[4]), 8'hA);
    chk("t4_f",  8'(d1_f),    8'hA);
    start1 = 1'b1; tick(); tick(); tick(); start1 = 1'b0;
    chk_d1("t4_sel7", 3'd7, 1'b1, 1'b1, 1'b0);
    tick();
    chk_d1("t4_done", 3'd7, 1'b0, 1'b0, 1'b1);
    tick();
    chk_d1("t4_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // 5. async reset at sel=6
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk_d1("t5_sel6", 3'd6, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_d1("t5_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) chk("t5_rst_i", 8'(d1_i[k]), 8'h0);
    rst = 1'b0;
    tick();
    chk_d1("t5_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk_d1("t5_restart", 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_d1("t5_sel1", 3'd1, 1'b1, 1'b0, 1'b0);
    stop1 = 1'b1; tick(); stop1 = 1'b0;
    chk_d1("t5_stop", 3'd0, 1'b0, 1'b0, 1'b0);

    // 6. drop loop_en at sel=2, then stop racing the final step
    loop_en = 1'b1;
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick();
    chk_d1("t6_sel2", 3'd2, 1'b1, 1'b0, 1'b0);
    loop_en = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk_d1("t6_sel7", 3'd7, 1'b1, 1'b1, 1'b0);
    tick();
    chk_d1("t6_done", 3'd7, 1'b0, 1'b0, 1'b1);
    tick();
    chk_d1("t6_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk_d1("t6b_sel7", 3'd7, 1'b1, 1'b1, 1'b0);
    stop1 = 1'b1; tick(); stop1 = 1'b0;
    chk_d1("t6b_stop", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_d1("t6b_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
